// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI-Lite bus widths shared by the arbiter, its interface and the bench
package axil_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
endpackage

// File: rtl/axil_if.sv
// rtl/axil_if.sv - AXI-Lite bundle (AW/W/B/AR/R) with slave-side and master-side modports
// s_axil: the view of a port that receives requests (addresses/data/valids in, readies/responses out)
// m_axil: the view of a port that issues requests (addresses/data/valids out, readies/responses in)
interface axil_if;
    logic [axil_pkg::AXI_ADDR_WIDTH-1:0] awaddr;
    logic                                awvalid;
    logic                                awready;
    logic [axil_pkg::AXI_DATA_WIDTH-1:0] wdata;
    logic [axil_pkg::AXI_STRB_WIDTH-1:0] wstrb;
    logic                                wvalid;
    logic                                wready;
    logic [1:0]                          bresp;
    logic                                bvalid;
    logic                                bready;
    logic [axil_pkg::AXI_ADDR_WIDTH-1:0] araddr;
    logic                                arvalid;
    logic                                arready;
    logic [axil_pkg::AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                          rresp;
    logic                                rvalid;
    logic                                rready;

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_arb_2x1.sv
// rtl/axil_arb_2x1.sv - two-requester round-robin AXI-Lite arbiter onto one shared slave
// aclk     : clock, all state on rising edge
// aresetn  : synchronous active-low reset
// s_axil0  : requester 0 (wins the first tie after reset)
// s_axil1  : requester 1
// m_axil   : shared downstream AXI-Lite slave
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, one transaction each in flight.
module axil_arb_2x1 (
    input  logic   aclk,
    input  logic   aresetn,
    axil_if.s_axil s_axil0,
    axil_if.s_axil s_axil1,
    axil_if.m_axil m_axil
);
    import axil_pkg::*;

    typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_RESP} rd_state_t;

    wr_state_t wr_state, wr_state_n;
    rd_state_t rd_state, rd_state_n;
    logic      wr_grant, wr_grant_n, last_wr, last_wr_n;
    logic      aw_done, aw_done_n, w_done, w_done_n;
    logic      rd_grant, rd_grant_n, last_rd, last_rd_n;

    // Phase qualifiers are gated with aresetn so every valid/ready drops in the
    // same cycle reset is asserted, even if the FSM is caught mid-transaction.
    logic wr_fwd, wr_resp, rd_fwd, rd_resp;
    assign wr_fwd  = aresetn && (wr_state == WR_FWD);
    assign wr_resp = aresetn && (wr_state == WR_RESP);
    assign rd_fwd  = aresetn && (rd_state == RD_FWD);
    assign rd_resp = aresetn && (rd_state == RD_RESP);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state <= WR_IDLE;
            wr_grant <= 1'b0;
            last_wr  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rd_state <= RD_IDLE;
            rd_grant <= 1'b0;
            last_rd  <= 1'b1;
        end else begin
            wr_state <= wr_state_n;
            wr_grant <= wr_grant_n;
            last_wr  <= last_wr_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            rd_state <= rd_state_n;
            rd_grant <= rd_grant_n;
            last_rd  <= last_rd_n;
        end
    end

    // Write path next state
    always_comb begin
        wr_state_n = wr_state;
        wr_grant_n = wr_grant;
        last_wr_n  = last_wr;
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        case (wr_state)
            WR_IDLE: begin
                if (s_axil0.awvalid || s_axil1.awvalid) begin
                    // On a tie the requester that was not served last wins.
                    wr_grant_n = (s_axil0.awvalid && s_axil1.awvalid) ? ~last_wr : s_axil1.awvalid;
                    wr_state_n = WR_FWD;
                end
            end
            WR_FWD: begin
                aw_done_n = aw_done | (m_axil.awvalid && m_axil.awready);
                w_done_n  = w_done  | (m_axil.wvalid  && m_axil.wready);
                if (aw_done_n && w_done_n) begin
                    wr_state_n = WR_RESP;
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid && m_axil.bready) begin
                    wr_state_n = WR_IDLE;
                    last_wr_n  = wr_grant;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    // Read path next state
    always_comb begin
        rd_state_n = rd_state;
        rd_grant_n = rd_grant;
        last_rd_n  = last_rd;
        case (rd_state)
            RD_IDLE: begin
                if (s_axil0.arvalid || s_axil1.arvalid) begin
                    rd_grant_n = (s_axil0.arvalid && s_axil1.arvalid) ? ~last_rd : s_axil1.arvalid;
                    rd_state_n = RD_FWD;
                end
            end
            RD_FWD: begin
                if (m_axil.arvalid && m_axil.arready) rd_state_n = RD_RESP;
            end
            RD_RESP: begin
                if (m_axil.rvalid && m_axil.rready) begin
                    rd_state_n = RD_IDLE;
                    last_rd_n  = rd_grant;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    // Datapath muxes and handshake steering
    always_comb begin
        m_axil.awaddr  = wr_grant ? s_axil1.awaddr : s_axil0.awaddr;
        m_axil.wdata   = wr_grant ? s_axil1.wdata  : s_axil0.wdata;
        m_axil.wstrb   = wr_grant ? s_axil1.wstrb  : s_axil0.wstrb;
        // Once a channel has handshaken its valid is masked so the slave never sees it twice.
        m_axil.awvalid = wr_fwd && !aw_done && (wr_grant ? s_axil1.awvalid : s_axil0.awvalid);
        m_axil.wvalid  = wr_fwd && !w_done  && (wr_grant ? s_axil1.wvalid  : s_axil0.wvalid);
        m_axil.bready  = wr_resp && (wr_grant ? s_axil1.bready : s_axil0.bready);
        m_axil.araddr  = rd_grant ? s_axil1.araddr : s_axil0.araddr;
        m_axil.arvalid = rd_fwd && (rd_grant ? s_axil1.arvalid : s_axil0.arvalid);
        m_axil.rready  = rd_resp && (rd_grant ? s_axil1.rready : s_axil0.rready);

        s_axil0.awready = wr_fwd && !wr_grant && !aw_done && m_axil.awready;
        s_axil1.awready = wr_fwd &&  wr_grant && !aw_done && m_axil.awready;
        s_axil0.wready  = wr_fwd && !wr_grant && !w_done  && m_axil.wready;
        s_axil1.wready  = wr_fwd &&  wr_grant && !w_done  && m_axil.wready;
        s_axil0.bvalid  = wr_resp && !wr_grant && m_axil.bvalid;
        s_axil1.bvalid  = wr_resp &&  wr_grant && m_axil.bvalid;
        s_axil0.bresp   = m_axil.bresp;
        s_axil1.bresp   = m_axil.bresp;

        s_axil0.arready = rd_fwd && !rd_grant && m_axil.arready;
        s_axil1.arready = rd_fwd &&  rd_grant && m_axil.arready;
        s_axil0.rvalid  = rd_resp && !rd_grant && m_axil.rvalid;
        s_axil1.rvalid  = rd_resp &&  rd_grant && m_axil.rvalid;
        s_axil0.rdata   = m_axil.rdata;
        s_axil1.rdata   = m_axil.rdata;
        s_axil0.rresp   = m_axil.rresp;
        s_axil1.rresp   = m_axil.rresp;
    end
endmodule

// File: tb/tb_axil_arb_2x1.sv
// tb/tb_axil_arb_2x1.sv - directed self-checking bench for axil_arb_2x1 with a small AXI-Lite RAM model
module tb_axil_arb_2x1;
    logic aclk;
    logic aresetn;

    axil_if s0_if();
    axil_if s1_if();
    axil_if m_if();

    axil_arb_2x1 dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axil0 (s0_if),
        .s_axil1 (s1_if),
        .m_axil  (m_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // requester drive and observe arrays
    logic [31:0] req_awaddr [2];
    logic        req_awvalid[2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wstrb  [2];
    logic        req_wvalid [2];
    logic        req_bready [2];
    logic [31:0] req_araddr [2];
    logic        req_arvalid[2];
    logic        req_rready [2];
    logic        rsp_awready[2];
    logic        rsp_wready [2];
    logic        rsp_bvalid [2];
    logic [1:0]  rsp_bresp  [2];
    logic        rsp_arready[2];
    logic        rsp_rvalid [2];
    logic [31:0] rsp_rdata  [2];
    logic [1:0]  rsp_rresp  [2];

    assign s0_if.awaddr  = req_awaddr[0];  assign s1_if.awaddr  = req_awaddr[1];
    assign s0_if.awvalid = req_awvalid[0]; assign s1_if.awvalid = req_awvalid[1];
    assign s0_if.wdata   = req_wdata[0];   assign s1_if.wdata   = req_wdata[1];
    assign s0_if.wstrb   = req_wstrb[0];   assign s1_if.wstrb   = req_wstrb[1];
    assign s0_if.wvalid  = req_wvalid[0];  assign s1_if.wvalid  = req_wvalid[1];
    assign s0_if.bready  = req_bready[0];  assign s1_if.bready  = req_bready[1];
    assign s0_if.araddr  = req_araddr[0];  assign s1_if.araddr  = req_araddr[1];
    assign s0_if.arvalid = req_arvalid[0]; assign s1_if.arvalid = req_arvalid[1];
    assign s0_if.rready  = req_rready[0];  assign s1_if.rready  = req_rready[1];
    assign rsp_awready[0] = s0_if.awready; assign rsp_awready[1] = s1_if.awready;
    assign rsp_wready[0]  = s0_if.wready;  assign rsp_wready[1]  = s1_if.wready;
    assign rsp_bvalid[0]  = s0_if.bvalid;  assign rsp_bvalid[1]  = s1_if.bvalid;
    assign rsp_bresp[0]   = s0_if.bresp;   assign rsp_bresp[1]   = s1_if.bresp;
    assign rsp_arready[0] = s0_if.arready; assign rsp_arready[1] = s1_if.arready;
    assign rsp_rvalid[0]  = s0_if.rvalid;  assign rsp_rvalid[1]  = s1_if.rvalid;
    assign rsp_rdata[0]   = s0_if.rdata;   assign rsp_rdata[1]   = s1_if.rdata;
    assign rsp_rresp[0]   = s0_if.rresp;   assign rsp_rresp[1]   = s1_if.rresp;

    // AXI-Lite RAM: 16 words, initialised to 0x5A000000 + word index on reset
    logic [31:0] mem [16];
    logic        sl_aw_got, sl_w_got, sl_bvalid, sl_rvalid;
    logic [31:0] sl_addr, sl_wdata, sl_rdata;
    logic [3:0]  sl_wstrb;
    wire         sl_aw_hs   = m_if.awvalid && m_if.awready;
    wire         sl_w_hs    = m_if.wvalid && m_if.wready;
    wire  [31:0] sl_eff_adr = sl_aw_hs ? m_if.awaddr : sl_addr;
    wire  [31:0] sl_eff_dat = sl_w_hs ? m_if.wdata : sl_wdata;
    wire  [3:0]  sl_eff_stb = sl_w_hs ? m_if.wstrb : sl_wstrb;

    assign m_if.awready = !sl_aw_got && !sl_bvalid;
    assign m_if.wready  = !sl_w_got && !sl_bvalid;
    assign m_if.bvalid  = sl_bvalid;
    assign m_if.bresp   = 2'b00;
    assign m_if.arready = !sl_rvalid;
    assign m_if.rvalid  = sl_rvalid;
    assign m_if.rdata   = sl_rdata;
    assign m_if.rresp   = 2'b00;

    always @(posedge aclk) begin
        if (!aresetn) begin
            sl_aw_got <= 1'b0;
            sl_w_got  <= 1'b0;
            sl_bvalid <= 1'b0;
            sl_rvalid <= 1'b0;
            sl_rdata  <= '0;
            sl_addr   <= '0;
            sl_wdata  <= '0;
            sl_wstrb  <= '0;
            for (int k = 0; k < 16; k++) mem[k] <= 32'h5A00_0000 + 32'(k);
        end else begin
            if (sl_aw_hs) begin sl_aw_got <= 1'b1; sl_addr <= m_if.awaddr; end
            if (sl_w_hs) begin sl_w_got <= 1'b1; sl_wdata <= m_if.wdata; sl_wstrb <= m_if.wstrb; end
            if ((sl_aw_got || sl_aw_hs) && (sl_w_got || sl_w_hs)) begin
                for (int b = 0; b < 4; b++)
                    if (sl_eff_stb[b]) mem[sl_eff_adr[5:2]][8*b +: 8] <= sl_eff_dat[8*b +: 8];
                sl_bvalid <= 1'b1;
                sl_aw_got <= 1'b0;
                sl_w_got  <= 1'b0;
            end
            if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                sl_rvalid <= 1'b1;
                sl_rdata  <= mem[m_if.araddr[5:2]];
            end else if (sl_rvalid && m_if.rready) begin
                sl_rvalid <= 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int wr_log[$];
    int rd_log[$];
    int excl_bad = 0;
    int bp_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack_log(input int q[$]);
        logic [7:0] v = '0;
        for (int k = 0; k < q.size() && k < 8; k++) v[k] = q[k][0];
        return v;
    endfunction

    function automatic logic [14:0] all_flags();
        return {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
                s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
                s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid};
    endfunction

    // grant order from upstream address handshakes; both requesters never see ready/valid at once
    initial forever begin
        @(negedge aclk);
        if (aresetn) begin
            for (int i = 0; i < 2; i++) begin
                if (req_awvalid[i] && rsp_awready[i]) wr_log.push_back(i);
                if (req_arvalid[i] && rsp_arready[i]) rd_log.push_back(i);
            end
            if ((rsp_awready[0] && rsp_awready[1]) || (rsp_wready[0] && rsp_wready[1]) ||
                (rsp_bvalid[0] && rsp_bvalid[1]) || (rsp_arready[0] && rsp_arready[1]) ||
                (rsp_rvalid[0] && rsp_rvalid[1]))
                excl_bad++;
        end
    end

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            req_awaddr[i] = '0; req_awvalid[i] = 1'b0; req_wdata[i] = '0; req_wstrb[i] = '0;
            req_wvalid[i] = 1'b0; req_bready[i] = 1'b0; req_araddr[i] = '0;
            req_arvalid[i] = 1'b0; req_rready[i] = 1'b0;
        end
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic do_write(input int i, input logic [31:0] addr, input logic [31:0] data,
                            input int bdelay, output logic [1:0] resp);
        int  hold;
        bit  got, hs_aw, hs_w;
        @(posedge aclk); #1;
        req_awaddr[i] = addr; req_awvalid[i] = 1'b1;
        req_wdata[i] = data; req_wstrb[i] = 4'hF; req_wvalid[i] = 1'b1;
        req_bready[i] = (bdelay == 0);
        hold = bdelay;
        got = 1'b0;
        resp = 2'bxx;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge aclk);
            hs_aw = req_awvalid[i] && rsp_awready[i];
            hs_w  = req_wvalid[i] && rsp_wready[i];
            if (rsp_bvalid[i]) begin
                if (hold > 0) begin
                    if (m_if.bready !== 1'b0) bp_bad++;
                    hold--;
                end else if (req_bready[i]) begin
                    got = 1'b1;
                    resp = rsp_bresp[i];
                end
            end
            @(posedge aclk); #1;
            if (hs_aw) req_awvalid[i] = 1'b0;
            if (hs_w) req_wvalid[i] = 1'b0;
            if (hold == 0) req_bready[i] = 1'b1;
        end
        req_bready[i] = 1'b0;
        check("wr_done", 32'(got), 32'd1);
    endtask

    task automatic do_read(input int i, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        bit got, hs_ar;
        @(posedge aclk); #1;
        req_araddr[i] = addr; req_arvalid[i] = 1'b1; req_rready[i] = 1'b1;
        got = 1'b0;
        data = 'x;
        resp = 2'bxx;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge aclk);
            hs_ar = req_arvalid[i] && rsp_arready[i];
            if (rsp_rvalid[i] && req_rready[i]) begin
                got = 1'b1;
                data = rsp_rdata[i];
                resp = rsp_rresp[i];
            end
            @(posedge aclk); #1;
            if (hs_ar) req_arvalid[i] = 1'b0;
        end
        req_rready[i] = 1'b0;
        check("rd_done", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    logic [31:0] d0, d1, rd0 [3], rd1 [3];
    logic [1:0]  r0, r1;

    initial begin
        do_reset();

        // reset state
        @(negedge aclk);
        check("reset_flags", 32'(all_flags()), 32'd0);

        // single write from s0, forwarded exactly one cycle after request
        @(posedge aclk); #1;
        req_awaddr[0] = 32'h04; req_awvalid[0] = 1'b1;
        req_wdata[0] = 32'hDEADBEEF; req_wstrb[0] = 4'hF; req_wvalid[0] = 1'b1;
        req_bready[0] = 1'b1;
        @(negedge aclk);
        check("idle_no_fwd", 32'({m_if.awvalid, m_if.wvalid}), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("fwd_valids", 32'({m_if.awvalid, m_if.wvalid}), 32'h3);
        check("fwd_awaddr", m_if.awaddr, 32'h04);
        check("fwd_wdata", m_if.wdata, 32'hDEADBEEF);
        check("s0_readies", 32'({rsp_awready[0], rsp_wready[0]}), 32'h3);
        check("s1_quiet", 32'({rsp_awready[1], rsp_wready[1], rsp_bvalid[1]}), 32'd0);
        @(posedge aclk); #1;
        req_awvalid[0] = 1'b0; req_wvalid[0] = 1'b0;
        @(negedge aclk);
        check("s0_bvalid", 32'(rsp_bvalid[0]), 32'd1);
        check("s0_bresp", 32'(rsp_bresp[0]), 32'd0);
        check("m_bready", 32'(m_if.bready), 32'd1);
        check("s1_no_bvalid", 32'(rsp_bvalid[1]), 32'd0);
        @(posedge aclk); #1;
        req_bready[0] = 1'b0;
        @(negedge aclk);
        check("s0_b_done", 32'(rsp_bvalid[0]), 32'd0);
        do_read(1, 32'h04, d1, r1);
        check("rb_04", d1, 32'hDEADBEEF);

        // simultaneous writes to 0x08 after reset: s0 first, s1 last
        do_reset();
        wr_log.delete();
        fork
            do_write(0, 32'h08, 32'h11111111, 0, r0);
            do_write(1, 32'h08, 32'h22222222, 0, r1);
        join
        check("tie_nwr", 32'(wr_log.size()), 32'd2);
        check("tie_order", 32'(pack_log(wr_log)), 32'h2);
        check("tie_bresp", 32'({r0, r1}), 32'd0);
        do_read(0, 32'h08, d0, r0);
        check("rb_08", d0, 32'h22222222);

        // fairness: both requesters stream three reads each
        do_reset();
        rd_log.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) do_read(0, 32'(4 * k), rd0[k], r0);
            end
            begin
                for (int k = 0; k < 3; k++) do_read(1, 32'(32 + 4 * k), rd1[k], r1);
            end
        join
        check("rr_nrd", 32'(rd_log.size()), 32'd6);
        check("rr_order", 32'(pack_log(rd_log)), 32'h2A);
        for (int k = 0; k < 3; k++) begin
            check("rr_data0", rd0[k], 32'h5A00_0000 + 32'(k));
            check("rr_data1", rd1[k], 32'h5A00_0008 + 32'(k));
        end

        // concurrent write (s0) and read (s1)
        fork
            do_write(0, 32'h10, 32'hA5A5A5A5, 0, r0);
            do_read(1, 32'h0C, d1, r1);
        join
        check("cc_bresp", 32'(r0), 32'd0);
        check("cc_rdata", d1, 32'h5A00_0003);
        check("cc_rresp", 32'(r1), 32'd0);
        do_read(1, 32'h10, d1, r1);
        check("rb_10", d1, 32'hA5A5A5A5);

        // backpressure: s1 holds bready low for 5 cycles while s0 waits
        wr_log.delete();
        fork
            do_write(1, 32'h14, 32'h33333333, 5, r1);
            begin
                repeat (2) @(posedge aclk);
                do_write(0, 32'h18, 32'h44444444, 0, r0);
            end
        join
        check("bp_bready_low", 32'(bp_bad), 32'd0);
        check("bp_order", 32'(pack_log(wr_log)), 32'h1);
        check("bp_nwr", 32'(wr_log.size()), 32'd2);
        do_read(0, 32'h18, d0, r0);
        check("rb_18", d0, 32'h44444444);

        // reset while the write path waits in its response phase
        @(posedge aclk); #1;
        req_awaddr[0] = 32'h1C; req_awvalid[0] = 1'b1;
        req_wdata[0] = 32'h55555555; req_wstrb[0] = 4'hF; req_wvalid[0] = 1'b1;
        req_bready[0] = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        req_awvalid[0] = 1'b0; req_wvalid[0] = 1'b0;
        @(negedge aclk);
        check("pre_rst_bvalid", 32'(rsp_bvalid[0]), 32'd1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(negedge aclk);
        check("in_rst_flags", 32'(all_flags()), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("post_rst_flags", 32'(all_flags()), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_flags", 32'(all_flags()), 32'd0);
        wr_log.delete();
        fork
            do_write(0, 32'h20, 32'h66666666, 0, r0);
            do_write(1, 32'h24, 32'h77777777, 0, r1);
        join
        check("rst_tie_order", 32'(pack_log(wr_log)), 32'h2);
        check("rst_tie_nwr", 32'(wr_log.size()), 32'd2);

        check("exclusive", 32'(excl_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
